// File: rtl/ins_sorter_topk_if.sv
// rtl/ins_sorter_topk_if.sv - tuple input stream, sorted output stream and status of the top-K sorter
// The master side feeds tuples and consumes results; the slave side is the sorter.
interface ins_sorter_topk_if #(
   parameter int NUM_POINTS = 1000,
   parameter int DIST_W     = 36,
   parameter int DEPTH      = 1000
);
   localparam int PT_W  = $clog2(NUM_POINTS);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DIST_W-1:0] in_dist;
   logic [PT_W-1:0]   in_pointa;
   logic [PT_W-1:0]   in_pointb;
   logic              in_last;
   logic              in_vld;
   logic              in_rdy;
   logic [DIST_W-1:0] out_dist;
   logic [PT_W-1:0]   out_pointa;
   logic [PT_W-1:0]   out_pointb;
   logic              out_last;
   logic              out_vld;
   logic              out_rdy;
   logic [CNT_W-1:0]  count;
   logic              dropped;

   modport master (
      output in_dist, in_pointa, in_pointb, in_last, in_vld, out_rdy,
      input  in_rdy, out_dist, out_pointa, out_pointb, out_last, out_vld, count, dropped
   );

   modport slave (
      input  in_dist, in_pointa, in_pointb, in_last, in_vld, out_rdy,
      output in_rdy, out_dist, out_pointa, out_pointb, out_last, out_vld, count, dropped
   );
endinterface

// File: rtl/ins_sorter_topk.sv
// rtl/ins_sorter_topk.sv - top-K insertion sorter with FILL/DRAIN modes and two-sided backpressure
// Entries are kept sorted best-first; a new tuple is placed with one parallel
// compare/shift per beat, and DRAIN pops the head one entry per accepted beat.
module ins_sorter_topk #(
   parameter int NUM_POINTS = 1000,
   parameter int DIST_W     = 36,
   parameter int DEPTH      = 1000,
   parameter bit SORT_OP    = 1'b0
) (
   input logic              clk,
   input logic              rst,
   ins_sorter_topk_if.slave bus
);
   localparam int PT_W  = $clog2(NUM_POINTS);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = DIST_W + 2 * PT_W;

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ENT_W-1:0] ent     [DEPTH];
   logic [ENT_W-1:0] ent_up  [DEPTH];
   logic [ENT_W-1:0] ent_dn  [DEPTH];
   logic [ENT_W-1:0] new_ent;
   logic [DEPTH-1:0] keep;
   logic [DEPTH-1:0] keep_prev;
   logic [CNT_W-1:0] cnt;
   logic             drop_r;
   logic             full;
   logic             in_acc;
   logic             out_acc;

   // keep[j]: valid entry j is better-or-equal to the incoming tuple, so it stays put.
   // Because the array is sorted these flags form a prefix of ones; ties keep the older entry ahead.
   always_comb begin
      new_ent = {bus.in_dist, bus.in_pointa, bus.in_pointb};
      for (int j = 0; j < DEPTH; j++) begin
         if (SORT_OP)
            keep[j] = (CNT_W'(j) < cnt) && (ent[j][ENT_W-1 -: DIST_W] >= bus.in_dist);
         else
            keep[j] = (CNT_W'(j) < cnt) && (ent[j][ENT_W-1 -: DIST_W] <= bus.in_dist);
      end
   end

   // Neighbour views: keep_prev marks the insertion slot boundary, ent_up/ent_dn are the shifted arrays.
   always_comb begin
      keep_prev[0]      = 1'b1;
      ent_up[0]         = new_ent;
      ent_dn[DEPTH-1]   = ent[DEPTH-1];
      for (int j = 1; j < DEPTH; j++) begin
         keep_prev[j] = keep[j-1];
         ent_up[j]    = ent[j-1];
      end
      for (int j = 0; j < DEPTH - 1; j++) begin
         ent_dn[j] = ent[j+1];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= FILL;
      else
         state <= state_nxt;
   end

   // Next state: the accepted last input starts DRAIN, the accepted last output returns to FILL.
   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (in_acc && bus.in_last) state_nxt = DRAIN;
         DRAIN:   if (out_acc && bus.out_last) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // Handshake outputs and accept strobes; reset forces both sides idle in the reset cycle.
   always_comb begin
      full         = (cnt == CNT_W'(DEPTH));
      bus.in_rdy   = (state == FILL) && !rst;
      bus.out_vld  = (state == DRAIN) && (cnt != '0) && !rst;
      bus.out_last = (state == DRAIN) && (cnt == CNT_W'(1)) && !rst;
      in_acc       = bus.in_vld && bus.in_rdy;
      out_acc      = bus.out_vld && bus.out_rdy;
   end

   // Storage update: insert-and-shift on an accepted input, pop-and-shift on an accepted output.
   // When full the tail is overwritten by the shift (evicted) or the new tuple is refused.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < DEPTH; j++) ent[j] <= '0;
         cnt    <= '0;
         drop_r <= 1'b0;
      end else begin
         drop_r <= in_acc && full;
         if (in_acc) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (!keep[j]) ent[j] <= keep_prev[j] ? new_ent : ent_up[j];
            end
            if (!full) cnt <= cnt + CNT_W'(1);
         end else if (out_acc) begin
            for (int j = 0; j < DEPTH; j++) ent[j] <= ent_dn[j];
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   assign bus.out_dist   = ent[0][ENT_W-1 -: DIST_W];
   assign bus.out_pointa = ent[0][2*PT_W-1 -: PT_W];
   assign bus.out_pointb = ent[0][PT_W-1:0];
   assign bus.count      = cnt;
   assign bus.dropped    = drop_r;
endmodule

// File: tb/tb_ins_sorter_topk.sv
// tb/tb_ins_sorter_topk.sv - directed self-checking bench for ins_sorter_topk
module tb_ins_sorter_topk;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  sel;
   logic [35:0] drv_dist;
   logic [9:0]  drv_pa;
   logic        drv_last;
   logic        drv_vld;
   logic        drv_rdy;
   int          n_chk  = 0;
   int          n_fail = 0;

   logic [35:0] obs_dist;
   logic [9:0]  obs_pa;
   logic [9:0]  obs_pb;
   logic        obs_last;
   logic        obs_vld;
   logic        obs_in_rdy;
   logic [2:0]  obs_count;
   logic        obs_dropped;

   always #5 clk = ~clk;

   ins_sorter_topk_if #(.NUM_POINTS(1000), .DIST_W(36), .DEPTH(4)) b0 ();
   ins_sorter_topk_if #(.NUM_POINTS(1000), .DIST_W(36), .DEPTH(4)) b1 ();
   ins_sorter_topk_if #(.NUM_POINTS(1000), .DIST_W(36), .DEPTH(3)) b2 ();

   assign b0.in_dist = drv_dist;  assign b0.in_pointa = drv_pa;  assign b0.in_pointb = drv_pa + 10'd1;
   assign b0.in_last = drv_last;  assign b0.in_vld = drv_vld && (sel == 2'd0);  assign b0.out_rdy = drv_rdy && (sel == 2'd0);
   assign b1.in_dist = drv_dist;  assign b1.in_pointa = drv_pa;  assign b1.in_pointb = drv_pa + 10'd1;
   assign b1.in_last = drv_last;  assign b1.in_vld = drv_vld && (sel == 2'd1);  assign b1.out_rdy = drv_rdy && (sel == 2'd1);
   assign b2.in_dist = drv_dist;  assign b2.in_pointa = drv_pa;  assign b2.in_pointb = drv_pa + 10'd1;
   assign b2.in_last = drv_last;  assign b2.in_vld = drv_vld && (sel == 2'd2);  assign b2.out_rdy = drv_rdy && (sel == 2'd2);

   ins_sorter_topk #(.NUM_POINTS(1000), .DIST_W(36), .DEPTH(4), .SORT_OP(1'b0)) u_min4 (.clk(clk), .rst(rst), .bus(b0));
   ins_sorter_topk #(.NUM_POINTS(1000), .DIST_W(36), .DEPTH(4), .SORT_OP(1'b1)) u_max4 (.clk(clk), .rst(rst), .bus(b1));
   ins_sorter_topk #(.NUM_POINTS(1000), .DIST_W(36), .DEPTH(3), .SORT_OP(1'b0)) u_min3 (.clk(clk), .rst(rst), .bus(b2));

   always_comb begin
      obs_dist = b0.out_dist;  obs_pa = b0.out_pointa;  obs_pb = b0.out_pointb;  obs_last = b0.out_last;
      obs_vld = b0.out_vld;    obs_in_rdy = b0.in_rdy;  obs_count = b0.count;    obs_dropped = b0.dropped;
      case (sel)
         2'd1: begin
            obs_dist = b1.out_dist;  obs_pa = b1.out_pointa;  obs_pb = b1.out_pointb;  obs_last = b1.out_last;
            obs_vld = b1.out_vld;    obs_in_rdy = b1.in_rdy;  obs_count = b1.count;    obs_dropped = b1.dropped;
         end
         2'd2: begin
            obs_dist = b2.out_dist;  obs_pa = b2.out_pointa;  obs_pb = b2.out_pointb;  obs_last = b2.out_last;
            obs_vld = b2.out_vld;    obs_in_rdy = b2.in_rdy;  obs_count = 3'(b2.count); obs_dropped = b2.dropped;
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input int a, input bit l, input bit exp_drop);
      chk("push_in_rdy", 64'(obs_in_rdy), 64'd1);
      drv_dist = 36'(d);
      drv_pa   = 10'(a);
      drv_last = l;
      drv_vld  = 1'b1;
      @(posedge clk); #1;
      drv_vld  = 1'b0;
      drv_last = 1'b0;
      chk("dropped", 64'(obs_dropped), 64'(exp_drop));
   endtask

   task automatic pop(input int d, input int a, input bit l, input int c);
      chk("pop_out_vld", 64'(obs_vld), 64'd1);
      chk("pop_dist", 64'(obs_dist), 64'(d));
      chk("pop_pointa", 64'(obs_pa), 64'(a));
      chk("pop_pointb", 64'(obs_pb), 64'(a + 1));
      chk("pop_last", 64'(obs_last), 64'(l));
      chk("pop_count", 64'(obs_count), 64'(c));
      drv_rdy = 1'b1;
      @(posedge clk); #1;
      drv_rdy = 1'b0;
   endtask

   task automatic idle_check(input string tag);
      chk({tag, "_out_vld"}, 64'(obs_vld), 64'd0);
      chk({tag, "_count"}, 64'(obs_count), 64'd0);
      chk({tag, "_in_rdy"}, 64'(obs_in_rdy), 64'd1);
   endtask

   initial begin : stim
      int   idx;
      int   bp_d [3];
      bit   bp_r [5];
      bp_d = '{1, 2, 3};
      bp_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

      sel = 2'd0; rst = 1'b1; drv_dist = '0; drv_pa = '0; drv_last = 1'b0; drv_vld = 1'b0; drv_rdy = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_rdy", 64'(obs_in_rdy), 64'd0);
      chk("rst_out_vld", 64'(obs_vld), 64'd0);
      chk("rst_out_last", 64'(obs_last), 64'd0);
      chk("rst_count", 64'(obs_count), 64'd0);
      chk("rst_dropped", 64'(obs_dropped), 64'd0);
      chk("rst_out_dist", 64'(obs_dist), 64'd0);
      rst = 1'b0; #1;
      chk("post_rst_in_rdy", 64'(obs_in_rdy), 64'd1);

      // min, depth 4: 9,3,7,1(last) -> 1,3,7,9
      push(9, 1, 0, 0); push(3, 2, 0, 0); push(7, 3, 0, 0); push(1, 4, 1, 0);
      chk("t1_in_rdy_drain", 64'(obs_in_rdy), 64'd0);
      pop(1, 4, 0, 4); pop(3, 2, 0, 3); pop(7, 3, 0, 2); pop(9, 1, 1, 1);
      idle_check("t1_end");

      // min, depth 4 with eviction: 5,8,2,6,1,9(last) -> 1,2,5,6
      push(5, 1, 0, 0); push(8, 2, 0, 0); push(2, 3, 0, 0); push(6, 4, 0, 0);
      push(1, 5, 0, 1); push(9, 6, 1, 1);
      pop(1, 5, 0, 4); pop(2, 3, 0, 3); pop(5, 1, 0, 2); pop(6, 4, 1, 1);
      idle_check("t2_end");

      // max, depth 4: same stream -> 9,8,6,5
      sel = 2'd1; #1;
      push(5, 1, 0, 0); push(8, 2, 0, 0); push(2, 3, 0, 0); push(6, 4, 0, 0);
      push(1, 5, 0, 1); push(9, 6, 1, 1);
      pop(9, 6, 0, 4); pop(8, 2, 0, 3); pop(6, 4, 0, 2); pop(5, 1, 1, 1);
      idle_check("t3_end");

      // ties, min, depth 3: equal distances keep arrival order, fourth is dropped
      sel = 2'd2; #1;
      push(4, 1, 0, 0); push(4, 2, 0, 0); push(4, 3, 0, 0); push(4, 4, 1, 1);
      pop(4, 1, 0, 3); pop(4, 2, 0, 2); pop(4, 3, 1, 1);
      idle_check("t4_end");

      // backpressure on a 3-entry drain with out_rdy 1,0,0,1,1
      sel = 2'd0; #1;
      push(3, 1, 0, 0); push(1, 2, 0, 0); push(2, 3, 1, 0);
      idx = 0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_dist", 64'(obs_dist), 64'(bp_d[idx]));
         chk("bp_last", 64'(obs_last), 64'(idx == 2));
         chk("bp_in_rdy", 64'(obs_in_rdy), 64'd0);
         drv_rdy = bp_r[i];
         @(posedge clk); #1;
         if (bp_r[i]) idx++;
      end
      drv_rdy = 1'b0;
      idle_check("t5_end");

      // reset in the middle of a drain, with out_rdy high on the reset edge
      push(8, 1, 0, 0); push(6, 2, 0, 0); push(7, 3, 0, 0); push(5, 4, 1, 0);
      pop(5, 4, 0, 4);
      drv_rdy = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; drv_rdy = 1'b0; #1;
      idle_check("t6_rst");
      chk("t6_rst_dist", 64'(obs_dist), 64'd0);
      push(2, 7, 0, 0); push(1, 8, 1, 0);
      pop(1, 8, 0, 2); pop(2, 7, 1, 1);
      idle_check("t6_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ins_sorter_topk.md
# ins_sorter_topk

Parametrised top-K insertion sorter for the connection-distance pipeline. It accepts a stream of (distance, point A, point B) tuples at one per cycle and keeps the DEPTH best tuples in sorted order, where best means minimum or maximum distance according to SORT_OP. On the last input beat it switches to drain mode and streams the retained tuples out best-first over a valid/ready handshake, feeding the network LUT. Unlike the fixed shift-chain sorter, it honours SORT_OP, discards losers once full, reports occupancy and applies backpressure on both sides.

## Interface
- NUM_POINTS, 1000, number of points; PT_W = $clog2(NUM_POINTS)
- DIST_W, 36, distance width (unsigned)
- DEPTH, 1000, number of retained tuples (K); CNT_W = $clog2(DEPTH+1)
- SORT_OP, 0, 0 = keep smallest (ascending out), 1 = keep largest (descending out)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_dist  in  DIST_W  tuple distance
- in_pointa  in  PT_W  tuple point A index
- in_pointb  in  PT_W  tuple point B index
- in_last  in  1  final tuple of the current batch
- in_vld  in  1  input tuple valid
- in_rdy  out  1  sorter can accept a tuple
- out_dist  out  DIST_W  head tuple distance
- out_pointa  out  PT_W  head point A
- out_pointb  out  PT_W  head point B
- out_last  out  1  head is the final retained tuple
- out_vld  out  1  head valid
- out_rdy  in  1  consumer accepts head
- count  out  CNT_W  number of tuples currently held
- dropped  out  1  one-cycle pulse: the accepted tuple or the evicted tail was discarded

## Operation
- The storage is an array E[0..DEPTH-1] of {dist, pointa, pointb}. E[0] is best, and entries at index >= count are don't-care.
- States are FILL and DRAIN; reset enters FILL.
- FILL behaviour:
  - in_rdy = 1. A tuple is accepted when in_vld && in_rdy.
  - Compute p = number of valid entries j with E[j] better-or-equal to the new tuple. Min mode: E[j].dist <= in_dist. Max mode: E[j].dist >= in_dist.
  - Ties are stable: earlier tuples stay ahead of later ones.
  - If p < DEPTH: E[p] takes the new tuple, E[j+1] takes E[j] for p <= j < DEPTH-1, and count = min(count+1, DEPTH). If count was already DEPTH, the old E[DEPTH-1] is lost and dropped pulses.
  - If p == DEPTH (array full, new tuple worst or equal to worst): the array is unchanged and dropped pulses.
  - Insertion is a single-cycle parallel compare/shift with no stall.
  - An accepted beat with in_last = 1 completes the insert, then moves to DRAIN.
- DRAIN behaviour:
  - in_rdy = 0.
  - out_vld = (count != 0). The out_* fields reflect E[0] directly from registers.
  - out_last = (count == 1).
  - On out_vld && out_rdy: E[j] takes E[j+1] for all j, and count decrements by 1.
  - When the beat with out_last is accepted, the state returns to FILL with count = 0.
- Distances are compared as unsigned DIST_W-bit values; there is no arithmetic on distances.
- count never exceeds DEPTH and never wraps.

## Timing
- Reset values: in_rdy = 0 during the reset cycle and 1 on the following cycle (FILL); out_vld = 0; out_last = 0; count = 0; dropped = 0; out_* data = 0; state = FILL.
- Insert latency: a tuple accepted at edge N appears in E and count after edge N, so it is visible from cycle N+1.
- If in_last is accepted at edge N, out_vld asserts in cycle N+1 and in_rdy is 0 from cycle N+1.
- Throughput is 1 tuple/cycle in FILL and 1 tuple/cycle in DRAIN while out_rdy is held high. Draining K tuples takes K cycles.
- out_* must remain stable while out_vld && !out_rdy.
- dropped is registered and asserts in the cycle after the offending accept.
- A reset asserted mid-FILL or mid-DRAIN clears everything on that edge; no output handshake completes in that cycle.
- in_vld during DRAIN is ignored; the upstream must hold it, because in_rdy = 0.
- An in_last beat that is itself dropped (full, worst) still triggers DRAIN.

## Test plan
- DEPTH=4, SORT_OP=0, inputs dist 9,3,7,1 with last on 1 -> drain yields 1,3,7,9; out_last on 9; count 4,3,2,1,0; no dropped pulse.
- DEPTH=4, SORT_OP=0, inputs 5,8,2,6,1,9(last) -> dropped pulses after 1 (evicts 8) and after 9; drain yields 1,2,5,6.
- DEPTH=4, SORT_OP=1, inputs 5,8,2,6,1,9(last) -> drain yields 9,8,6,5.
- Ties: DEPTH=3, min, dist 4 (a=1), 4 (a=2), 4 (a=3), 4 (a=4, last) -> drain gives pointa 1,2,3; the fourth tuple is dropped.
- Backpressure: toggle out_rdy 1,0,0,1,1 during a 3-entry drain -> each value is held stable while stalled; all 3 beats are delivered in order; in_rdy is 0 until the beat after the out_last accept.
- Reset mid-DRAIN after 1 of 4 beats -> next cycle count = 0, out_vld = 0, in_rdy = 1; a new batch 2,1(last) drains 1,2.
